led_scan_pwm: RTL and testbench

- Parametrised multiplexed 7-segment display driver; successor to the fixed six-digit scanner.
- Scans NUM_DIGITS common-node digits with a clock-enable prescaler in the clk domain; the scan clock is never a divided clock.
- Adds tear-free frame capture, per-digit blink, brightness PWM and a frame-start strobe.
- Sits between the fnd_dec outputs and the board segment/enable pins in top.

---
 rtl/led_scan_pwm.sv | 141 ++++++++++++++
 tb/tb_led_scan_pwm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_pwm.sv
// Multiplexed 7-segment scanner with frame-synchronous capture, per-digit blink and PWM dimming.
// Optional anti-ghosting slot gap: define LED_SCAN_GHOST_GAP_EN.
module led_scan_pwm #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 5000,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*7-1:0] i_digit_seg,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  input  logic                    i_enable,
  output logic [6:0]              o_seg,
  output logic                    o_seg_dp,
  output logic [NUM_DIGITS-1:0]   o_seg_enb,
  output logic                    o_frame_start
);

  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int BKW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_DIV - 1);

  logic [PW-1:0]           presc_reg, presc_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [BRIGHT_W-1:0]     pwm_reg, pwm_next;
  logic [BKW-1:0]          blink_cnt_reg, blink_cnt_next;
  logic                    blink_phase_reg, blink_phase_next;
  logic                    en_d_reg;
  logic [NUM_DIGITS*7-1:0] shadow_seg_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   enb_reg, enb_next;
  logic                    frame_start_reg;

  logic [6:0] seg_slice [NUM_DIGITS];
  logic       run, rise, slot_end, frame_load;
  logic       pwm_lit, gap_open, blink_dark, digit_on;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slice
      assign seg_slice[gi] = shadow_seg_reg[7*gi +: 7];
    end
  endgenerate

  // The cycle enable rises is spent loading the frame; scanning proper starts the cycle after.
  assign run        = i_enable & en_d_reg;
  assign rise       = i_enable & ~en_d_reg;
  assign slot_end   = (presc_reg == PRESC_LAST);
  assign frame_load = rise | (run & slot_end & (idx_reg == IDX_LAST));

  always_comb begin
    presc_next = '0;
    idx_next   = '0;
    pwm_next   = '0;
    if (run) begin
      if (slot_end) begin
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        presc_next = presc_reg + 1'b1;
        idx_next   = idx_reg;
        pwm_next   = pwm_reg + 1'b1;
      end
    end
  end

  always_comb begin
    blink_cnt_next   = blink_cnt_reg + 1'b1;
    blink_phase_next = blink_phase_reg;
    if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_next   = '0;
      blink_phase_next = ~blink_phase_reg;
    end
  end

`ifdef LED_SCAN_GHOST_GAP_EN
  assign gap_open = (presc_reg >= PW'(4));
`else
  assign gap_open = 1'b1;
`endif

  assign pwm_lit    = (&i_brightness) | (pwm_reg < i_brightness);
  assign blink_dark = blink_phase_reg & i_blink_mask[idx_reg];
  assign digit_on   = run & pwm_lit & gap_open & ~blink_dark;

  always_comb begin
    seg_next = '0;
    dp_next  = 1'b0;
    enb_next = '1;
    if (run) begin
      seg_next = seg_slice[idx_reg];
      dp_next  = shadow_dp_reg[idx_reg];
    end
    if (digit_on) enb_next[idx_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg       <= '0;
      idx_reg         <= '0;
      pwm_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      en_d_reg        <= 1'b0;
      shadow_seg_reg  <= '0;
      shadow_dp_reg   <= '0;
      seg_reg         <= '0;
      dp_reg          <= 1'b0;
      enb_reg         <= '1;
      frame_start_reg <= 1'b0;
    end else begin
      presc_reg       <= presc_next;
      idx_reg         <= idx_next;
      pwm_reg         <= pwm_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      en_d_reg        <= i_enable;
      if (frame_load) begin
        shadow_seg_reg <= i_digit_seg;
        shadow_dp_reg  <= i_dp;
      end
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
      enb_reg         <= enb_next;
      frame_start_reg <= frame_load;
    end
  end

  assign o_seg         = seg_reg;
  assign o_seg_dp      = dp_reg;
  assign o_seg_enb     = enb_reg;
  assign o_frame_start = frame_start_reg;

endmodule

// File: tb/tb_led_scan_pwm.sv
// Directed self-checking bench for led_scan_pwm (4 digits, 8-clk slots, 2-bit brightness, 64-clk blink).
module tb_led_scan_pwm;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BW = 2;
  localparam int BD = 64;
`ifdef LED_SCAN_GHOST_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [ND*7-1:0] i_digit_seg;
  logic [ND-1:0]   i_dp;
  logic [ND-1:0]   i_blink_mask;
  logic [BW-1:0]   i_brightness;
  logic            i_enable;
  logic [6:0]      o_seg;
  logic            o_seg_dp;
  logic [ND-1:0]   o_seg_enb;
  logic            o_frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [6:0] exp_seg [ND];
  logic [ND-1:0] dp_val = 4'b0101;

  led_scan_pwm #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_digit_seg(i_digit_seg), .i_dp(i_dp),
    .i_blink_mask(i_blink_mask), .i_brightness(i_brightness), .i_enable(i_enable),
    .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb), .o_frame_start(o_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges seen since reset release; gives the blink phase the DUT should be in.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [12:0] exp_vec(int k, bit lit, bit fs);
    logic [3:0] e;
    e = 4'b1111;
    if (lit) e[k] = 1'b0;
    return {e, exp_seg[k], dp_val[k], fs};
  endfunction

  function automatic bit gap_open(int j);
    return GAP_EN ? (j >= 4) : 1'b1;
  endfunction

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_segs();
    i_digit_seg = {exp_seg[3], exp_seg[2], exp_seg[1], exp_seg[0]};
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b",
               {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, {4'b1111, 7'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL scan_sync: got no frame_start expected pulse"); end
    for (int k = 0; k < ND; k++)
      for (int j = 0; j < SD; j++) begin
        @(negedge clk);
        e = exp_vec(k, gap_open(j), (k == ND-1) && (j == SD-1));
        n_tests++;
        if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
          n_fail++;
          $display("FAIL scan d%0d c%0d: got %b expected %b", k, j,
                   {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
        end
      end
  endtask

  task automatic test_capture();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL capture_sync: got no frame_start expected pulse"); end
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < ND; k++)
        for (int j = 0; j < SD; j++) begin
          @(negedge clk);
          e = exp_vec(k, gap_open(j), (k == ND-1) && (j == SD-1));
          n_tests++;
          if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
            n_fail++;
            $display("FAIL capture f%0d d%0d c%0d: got %b expected %b", f, k, j,
                     {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
          end
          if (f == 0 && k == 1 && j == 1)
            i_digit_seg[14 +: 7] = 7'h7F;
          if (f == 0 && k == ND-1 && j == SD-1)
            exp_seg[2] = 7'h7F;
        end
  endtask

  task automatic test_brightness();
    bit ok;
    logic [12:0] e;
    int b;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 1 : (t == 1) ? 2 : 0;
      @(negedge clk);
      i_brightness = BW'(b);
      wait_frame(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL bright_sync b%0d: got no frame_start expected pulse", b); end
      for (int k = 0; k < ND; k++)
        for (int j = 0; j < SD; j++) begin
          @(negedge clk);
          e = exp_vec(k, gap_open(j) && ((j % 4) < b), (k == ND-1) && (j == SD-1));
          n_tests++;
          if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
            n_fail++;
            $display("FAIL bright b%0d d%0d c%0d: got %b expected %b", b, k, j,
                     {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
          end
        end
    end
    @(negedge clk);
    i_brightness = 2'b11;
  endtask

  task automatic test_blink();
    bit ok;
    bit phase;
    logic [12:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    i_blink_mask = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL blink_sync: got no frame_start expected pulse"); end
    for (int f = 0; f < 6; f++)
      for (int k = 0; k < ND; k++)
        for (int j = 0; j < SD; j++) begin
          @(negedge clk);
          phase = (((cyc - 1) / BD) % 2) == 1;
          e = exp_vec(k, gap_open(j) && !(k == 1 && phase), (k == ND-1) && (j == SD-1));
          n_tests++;
          if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
            n_fail++;
            $display("FAIL blink f%0d d%0d c%0d ph%0d: got %b expected %b", f, k, j, phase,
                     {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
          end
        end
    i_blink_mask = 4'b0000;
  endtask

  task automatic test_enable();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL enable_sync: got no frame_start expected pulse"); end
    repeat (12) @(negedge clk);
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== 13'b1111_0000000_0_0) begin
        n_fail++;
        $display("FAIL enable_off c%0d: got %b expected %b", i,
                 {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, 13'b1111_0000000_0_0);
      end
    end
    i_enable = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({o_seg_enb, o_frame_start} !== 5'b1111_1) begin
      n_fail++;
      $display("FAIL reenable_start: got %b expected %b", {o_seg_enb, o_frame_start}, 5'b1111_1);
    end
    @(negedge clk);
    e = exp_vec(0, gap_open(0), 1'b0);
    n_tests++;
    if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
      n_fail++;
      $display("FAIL reenable_digit0: got %b expected %b",
               {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_sync: got no frame_start expected pulse"); end
    repeat (22) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== 13'b1111_0000000_0_0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b",
               {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, 13'b1111_0000000_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_resync: got no frame_start expected pulse"); end
    for (int j = 0; j < SD; j++) begin
      @(negedge clk);
      e = exp_vec(0, gap_open(j), 1'b0);
      n_tests++;
      if ({o_seg_enb, o_seg, o_seg_dp, o_frame_start} !== e) begin
        n_fail++;
        $display("FAIL rstmid_resume c%0d: got %b expected %b", j,
                 {o_seg_enb, o_seg, o_seg_dp, o_frame_start}, e);
      end
    end
  endtask

  initial begin
    exp_seg[0] = 7'h4F;
    exp_seg[1] = 7'h5B;
    exp_seg[2] = 7'h06;
    exp_seg[3] = 7'h7E;
    drive_segs();
    i_dp         = dp_val;
    i_blink_mask = 4'b0000;
    i_brightness = 2'b11;
    i_enable     = 1'b1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_scan();
    test_capture();
    test_brightness();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
